// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader.
//   DATA_BUS_SIZE   : default word width, matches the FIFO data width.
//   occ_e           : skid-buffer occupancy (EMPTY / ONE / TWO).
//   FIFO_RD_LATENCY : cycles from a sampled FIFO read strobe to valid data_out.
//   occ_count()     : number of words held for a given occupancy state.
package fifo_stream_reader_pkg;

  localparam int DATA_BUS_SIZE   = 32;
  localparam int FIFO_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e occ);
    case (occ)
      OCC_ONE: occ_count = 2'd1;
      OCC_TWO: occ_count = 2'd2;
      default: occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry skid buffer with its occupancy state machine.
//   clk, rst_n   : clock and synchronous active-low reset.
//   capture      : a fetched word arrives on capture_data this cycle.
//   capture_data : word returned by the FIFO.
//   pop          : the head word is accepted downstream this cycle.
//   occ          : current occupancy state.
//   head_data    : oldest buffered word (stream output).
module reader_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] capture_data,
  input  logic                  pop,
  output occ_e                  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (capture) begin
          head_d = capture_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (capture && pop) begin
          head_d = capture_data;
        end else if (capture) begin
          tail_d = capture_data;
          occ_d  = OCC_TWO;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // Capture without pop cannot happen here: the credit rule in the
        // top never lets a third word be in flight.
        if (pop) begin
          head_d = tail_q;
          if (capture) begin
            tail_d = capture_data;
          end else begin
            occ_d  = OCC_ONE;
          end
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = head_q;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && !pop && occ_q == OCC_TWO));

  underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && occ_q == OCC_EMPTY));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (one-cycle read latency) onto a valid/ready
// stream at up to one word per cycle, marks burst ends and counts beats.
//   clk, rst_n : clock and synchronous active-low reset.
//   en         : allows new FIFO reads; already fetched words still drain.
//   fifo_rd    : FIFO read strobe (combinational).
//   fifo_empt  : FIFO empty flag.
//   fifo_data  : FIFO data_out, valid the cycle after a sampled read.
//   m_valid, m_ready, m_data, m_last : output stream.
//   words_sent : accepted beats since reset, wrapping.
//   busy       : a word is buffered or a read is in flight.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_SIZE,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd,
  input  logic                  fifo_empt,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic                  busy
);

  localparam int               BEAT_W       = 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  // Words that may be buffered or in flight at once: the read latency plus
  // the word currently on the output.
  localparam logic [1:0]        CREDIT_LIMIT = 2'(FIFO_RD_LATENCY + 1);

  occ_e                  occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  pop;
  logic [1:0]            credits_used;
  logic                  pending_q, pending_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;

  reader_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (pending_q),
    .capture_data (fifo_data),
    .pop          (pop),
    .occ          (occ),
    .head_data    (head_data)
  );

  assign m_valid = (occ != OCC_EMPTY);
  assign m_data  = head_data;
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid & (beat_q == LAST_BEAT);
  assign busy    = m_valid | pending_q;

  // pop implies at least one buffered word, so this cannot underflow.
  assign credits_used = occ_count(occ) + {1'b0, pending_q} - {1'b0, pop};
  assign fifo_rd      = rst_n & en & ~fifo_empt & (credits_used < CREDIT_LIMIT);

  always_comb begin
    pending_d = fifo_rd;
    beat_d    = beat_q;
    words_d   = words_q;
    if (pop) begin
      beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      words_d = words_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      beat_q    <= '0;
      words_q   <= '0;
    end else begin
      pending_q <= pending_d;
      beat_q    <= beat_d;
      words_q   <= words_d;
    end
  end

  assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int BL = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_rd;
  logic          fifo_empt = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] words_sent;
  logic          busy;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_rd    (fifo_rd),
    .fifo_empt  (fifo_empt),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .words_sent (words_sent),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered data_out and empty flag.
  logic [DW-1:0] fq[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fifo_data <= '0;
    end else if (fifo_rd && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
    end
    fifo_empt <= (fq.size() == 0);
  end

  // Reference model state: words expected in order, beats accepted,
  // reads issued, and the previous cycle's stall snapshot.
  logic [DW-1:0] exp_q[$];
  int            beats = 0;
  int            reads = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  // Called mid-cycle (negedge) with inputs stable.
  task automatic monitor();
    if (!rst_n) begin
      chk("rd_in_reset", fifo_rd, 0);
      return;
    end
    chk("rd_while_empty", fifo_rd & fifo_empt, 0);
    if (!en) chk("rd_while_en_low", fifo_rd, 0);
    chk("busy", busy, (reads - beats) != 0);
    chk("words_sent", words_sent, beats % (1 << CW));
    chk("m_last", m_last, m_valid && ((beats % BL) == BL - 1));
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else chk("m_data", m_data, exp_q.pop_front());
      beats++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (fifo_rd) reads++;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    beats = 0;
    reads = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    clear_model();
  endtask

  typedef struct {
    logic          rd;
    logic          vld;
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] words;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int rdcnt;
    int lastcnt;
    int lastpos;

    for (int k = 0; k < 11; k++) begin
      tbl[k].rd    = (k <= 7);
      tbl[k].vld   = (k >= 2 && k <= 9);
      tbl[k].data  = tbl[k].vld ? DW'(32'h11 + k - 2) : '0;
      tbl[k].last  = (k == 9);
      tbl[k].words = CW'((k < 2) ? 0 : ((k - 2 > 8) ? 8 : k - 2));
    end

    @(posedge clk);
    #1;
    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_words", words_sent, 0);

    // Stream 8 preloaded words with no backpressure.
    for (int i = 0; i < 8; i++) push(DW'(32'h11 + i));
    m_ready = 1'b1;
    cyc();
    en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("t1_rd", fifo_rd, tbl[k].rd);
      chk("t1_valid", m_valid, tbl[k].vld);
      if (tbl[k].vld) chk("t1_data", m_data, tbl[k].data);
      chk("t1_last", m_last, tbl[k].last);
      chk("t1_words", words_sent, tbl[k].words);
      monitor();
      @(posedge clk);
      #1;
    end

    // Backpressure: only two reads may be outstanding during a stall.
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'(32'hA0 + i));
    en = 1'b1;
    cyc();
    rdcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fifo_rd) rdcnt++;
      monitor();
      @(posedge clk);
      #1;
    end
    chk("t2_credits", rdcnt, 2);
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("t2_words", words_sent, 4);
    chk("t2_all_out", exp_q.size(), 0);

    // Alternating ready over two bursts.
    do_reset();
    for (int i = 0; i < 16; i++) push(DW'(32'hB00 + i));
    en = 1'b1;
    lastcnt = 0;
    for (int k = 0; k < 44; k++) begin
      m_ready = (k % 2 == 0);
      @(negedge clk);
      if (m_valid && m_ready && m_last) lastcnt++;
      monitor();
      @(posedge clk);
      #1;
    end
    chk("t3_beats", beats, 16);
    chk("t3_lasts", lastcnt, 2);

    // en dropped after three reads with the third still pending.
    do_reset();
    for (int i = 0; i < 10; i++) push(DW'(32'hC0 + i));
    m_ready = 1'b1;
    cyc();
    en = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    en = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
    chk("t4_reads", reads, 3);
    chk("t4_beats", beats, 3);
    chk("t4_busy", busy, 0);

    // Reset mid-burst with a full buffer.
    do_reset();
    for (int i = 0; i < 12; i++) push(DW'(32'hD0 + i));
    en = 1'b1;
    cyc();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    rst_n = 1'b0;
    m_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    clear_model();
    chk("t5_valid", m_valid, 0);
    chk("t5_words", words_sent, 0);
    chk("t5_busy", busy, 0);
    for (int i = 0; i < 8; i++) push(DW'(32'hE0 + i));
    lastcnt = 0;
    lastpos = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_last) begin
        lastcnt++;
        lastpos = beats + 1;
      end
      monitor();
      @(posedge clk);
      #1;
    end
    chk("t5_beats", beats, 8);
    chk("t5_lastcnt", lastcnt, 1);
    chk("t5_lastpos", lastpos, 8);

    // Counter wrap: 17 beats on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push(DW'(32'hF00 + i));
    en = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 24; k++) cyc();
    chk("t6_words", words_sent, 1);

    // Randomised traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(2) == 0) push($urandom);
      en = ($urandom_range(7) != 0);
      m_ready = ($urandom_range(2) != 0);
      cyc();
    end
    en = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 80 && (exp_q.size() > 0 || busy); k++) cyc();
    cyc();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
